// File: rtl/dmem_arbiter_pkg.sv
// Shared memory_io types and constants for the data-memory arbiter and its helpers.
// Holds the request/response structs, their idle values and the owner encoding.
package dmem_arbiter_pkg;

  typedef enum logic {
    MEM_CORE   = 1'b0,
    MEM_VECTOR = 1'b1
  } mem_owner_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic        do_read;
    logic        do_write;
    logic [7:0]  user_tag;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  user_tag;
  } memory_io_rsp;

  localparam memory_io_req memory_io_no_req = '0;
  localparam memory_io_rsp memory_io_no_rsp = '0;

endpackage

// File: rtl/owner_fifo.sv
// Small synchronous FIFO with an explicit occupancy count; reusable for any N-port arbiter
// that needs to remember who owns each in-flight transaction. DEPTH must be a power of two.
module owner_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between the scalar core and the
// vector unit; an owner FIFO steers each response back to whoever issued the request.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit CORE_FIRST      = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  memory_io_req                       core_req,
  output memory_io_rsp                       core_rsp,
  input  memory_io_req                       vec_req,
  output memory_io_rsp                       vec_rsp,
  output memory_io_req                       mem_req,
  input  memory_io_rsp                       mem_rsp,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               orphan_err
);

  mem_owner_t last_grant;
  mem_owner_t winner;
  mem_owner_t head_owner;
  logic [0:0] push_owner;
  logic [0:0] head_bits;
  logic       fifo_full;
  logic       fifo_empty;
  logic       can_accept;
  logic       accept;
  logic       pop;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    winner = MEM_CORE;
    if (core_req.valid && vec_req.valid) begin
      if (last_grant == MEM_CORE) winner = MEM_VECTOR;
    end else if (vec_req.valid) begin
      winner = MEM_VECTOR;
    end
  end

  // Full is the registered count, so a same-cycle pop never frees a slot early.
  assign can_accept = mem_rsp.ready && !fifo_full;
  assign accept     = can_accept && (core_req.valid || vec_req.valid) && !reset;
  assign pop        = mem_rsp.valid && !fifo_empty;
  assign push_owner = winner;
  assign head_owner = mem_owner_t'(head_bits);

  owner_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_owner),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  // Seeding the pointer with the opposite requester makes CORE_FIRST win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (CORE_FIRST) last_grant <= MEM_VECTOR;
      else            last_grant <= MEM_CORE;
    end else if (accept) begin
      last_grant <= winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                            orphan_err <= 1'b0;
    else if (mem_rsp.valid && fifo_empty) orphan_err <= 1'b1;
  end

  always_comb begin
    mem_req  = memory_io_no_req;
    core_rsp = memory_io_no_rsp;
    vec_rsp  = memory_io_no_rsp;
    if (!reset) begin
      if (accept) mem_req = (winner == MEM_VECTOR) ? vec_req : core_req;
      core_rsp.ready = accept && (winner == MEM_CORE);
      vec_rsp.ready  = accept && (winner == MEM_VECTOR);
      if (pop) begin
        if (head_owner == MEM_CORE) begin
          core_rsp.valid    = 1'b1;
          core_rsp.addr     = mem_rsp.addr;
          core_rsp.data     = mem_rsp.data;
          core_rsp.user_tag = mem_rsp.user_tag;
        end else begin
          vec_rsp.valid    = 1'b1;
          vec_rsp.addr     = mem_rsp.addr;
          vec_rsp.data     = mem_rsp.data;
          vec_rsp.user_tag = mem_rsp.user_tag;
        end
      end
    end
  end

endmodule
